// File: rtl/ifmap_spad_pkg.sv
// Shared types and constants for the ifmap scratchpad sequencer.
// Widths, FSM state encoding and config legality check.
package ifmap_spad_pkg;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 64;
    localparam int ADDR_W   = 6;
    localparam int LEN_W    = 7;
    localparam int FILT_W   = 5;
    localparam int MAX_FILT = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMP,
        FIN
    } state_e;

    // A job is illegal if the row is empty or oversized, the filter is
    // empty or oversized, or the filter is wider than the row.
    function automatic logic cfg_illegal(
        input logic [LEN_W-1:0]  len,
        input logic [FILT_W-1:0] filt
    );
        return (len == '0)
            || (len > LEN_W'(DEPTH))
            || (filt == '0)
            || (filt > FILT_W'(MAX_FILT))
            || (LEN_W'(filt) > len);
    endfunction

endpackage

// File: rtl/ifmap_win_agen.sv
// Sliding-window address generator: base/tap counters and tap flags.
// Advances one tap per fire; wraps tap and bumps base at window end.
module ifmap_win_agen
    import ifmap_spad_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              fire_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [FILT_W-1:0] filt_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              first_o,
    output logic              last_o,
    output logic              final_o
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [FILT_W-1:0] tap_q, tap_d;

    assign addr_o  = base_q + ADDR_W'(tap_q);
    assign first_o = (tap_q == '0);
    assign last_o  = (tap_q == filt_i - FILT_W'(1));
    assign final_o = last_o
                  && (LEN_W'(base_q) == len_i - LEN_W'(filt_i));

    // Next tap/base: hold on stall, wrap tap at end of each window.
    always_comb begin
        base_d = base_q;
        tap_d  = tap_q;
        if (clr_i) begin
            base_d = '0;
            tap_d  = '0;
        end else if (fire_i) begin
            if (last_o) begin
                tap_d  = '0;
                base_d = base_q + ADDR_W'(1);
            end else begin
                tap_d = tap_q + FILT_W'(1);
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            tap_q  <= '0;
        end else begin
            base_q <= base_d;
            tap_q  <= tap_d;
        end
    end

endmodule

// File: rtl/ifmap_spad_ctrl.sv
// Ifmap scratchpad sequencer: loads one row, then replays it as
// stride-1 windows of width S to the MAC over valid/ready.
module ifmap_spad_ctrl
    import ifmap_spad_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [FILT_W-1:0] cfg_filt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              spad_w_en,
    output logic [ADDR_W-1:0] spad_w_addr,
    output logic [DATA_W-1:0] spad_w_data,
    output logic              spad_r_en,
    output logic [ADDR_W-1:0] spad_r_addr,
    output logic              mac_valid,
    input  logic              mac_ready,
    output logic              mac_first,
    output logic              mac_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [FILT_W-1:0] filt_q;
    logic [ADDR_W-1:0] wcnt_q;
    logic              err_q;

    logic              in_comp;
    logic              accept;
    logic              fire;
    logic              ag_first;
    logic              ag_last;
    logic              ag_final;
    logic [ADDR_W-1:0] ag_addr;

    assign in_comp     = (state_q == COMP);
    assign accept      = (state_q == IDLE) && start;
    assign fire        = in_comp && mac_ready;

    assign in_ready    = (state_q == LOAD);
    assign spad_w_en   = in_ready && in_valid;
    assign spad_w_addr = wcnt_q;
    assign spad_w_data = in_data;

    assign spad_r_en   = in_comp;
    assign spad_r_addr = ag_addr;
    assign mac_valid   = in_comp;
    assign mac_first   = in_comp && ag_first;
    assign mac_last    = in_comp && ag_last;

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign err         = (state_q == FIN) && err_q;

    ifmap_win_agen u_agen (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (accept),
        .fire_i  (fire),
        .len_i   (len_q),
        .filt_i  (filt_q),
        .addr_o  (ag_addr),
        .first_o (ag_first),
        .last_o  (ag_last),
        .final_o (ag_final)
    );

    // Job FSM: config latch, load counter and phase sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            filt_q  <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q  <= cfg_len;
                        filt_q <= cfg_filt;
                        wcnt_q <= '0;
                        err_q  <= cfg_illegal(cfg_len, cfg_filt);
                        state_q <= cfg_illegal(cfg_len, cfg_filt)
                                 ? FIN : LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        wcnt_q <= wcnt_q + ADDR_W'(1);
                        if (LEN_W'(wcnt_q) == len_q - LEN_W'(1))
                            state_q <= COMP;
                    end
                end
                COMP: begin
                    if (mac_ready && ag_final)
                        state_q <= FIN;
                end
                FIN: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifmap_spad_ctrl.sv
// Directed bench for ifmap_spad_ctrl with an address/flag model.
// Inputs change at negedge; outputs sampled 1ns later.
module tb_ifmap_spad_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] cfg_len;
    logic [4:0] cfg_filt;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       spad_w_en;
    logic [5:0] spad_w_addr;
    logic [7:0] spad_w_data;
    logic       spad_r_en;
    logic [5:0] spad_r_addr;
    logic       mac_valid;
    logic       mac_ready;
    logic       mac_first;
    logic       mac_last;
    logic       busy;
    logic       done;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ifmap_spad_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_len     (cfg_len),
        .cfg_filt    (cfg_filt),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .spad_w_en   (spad_w_en),
        .spad_w_addr (spad_w_addr),
        .spad_w_data (spad_w_data),
        .spad_r_en   (spad_r_en),
        .spad_r_addr (spad_r_addr),
        .mac_valid   (mac_valid),
        .mac_ready   (mac_ready),
        .mac_first   (mac_first),
        .mac_last    (mac_last),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 0);
        chk({tag, ".w_en"}, 32'(spad_w_en), 0);
        chk({tag, ".r_en"}, 32'(spad_r_en), 0);
        chk({tag, ".mac_valid"}, 32'(mac_valid), 0);
        chk({tag, ".first"}, 32'(mac_first), 0);
        chk({tag, ".last"}, 32'(mac_last), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".err"}, 32'(err), 0);
    endtask

    // One job: start, load, replay windows, FIN. gaps randomises
    // in_valid/mac_ready; noise pulses start with junk cfg mid-job;
    // abort >= 0 asserts rst (with mac_ready low) at that tap index.
    task automatic run_job(input int len, input int filt,
                           input bit gaps, input bit noise,
                           input int abort);
        int w = 0;
        int b = 0;
        int t = 0;
        int taps = 0;
        int cyc = 0;
        int total;
        bit bad;
        bad = (len == 0) || (len > 64) || (filt == 0)
           || (filt > 16) || (filt > len);
        total = bad ? 0 : (len - filt + 1) * filt;

        @(negedge clk);
        cfg_len = 7'(len);
        cfg_filt = 5'(filt);
        start = 1'b1;
        #1;
        chk("start.busy", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("t1.busy", 32'(busy), 1);
        if (bad) begin
            chk("bad.done", 32'(done), 1);
            chk("bad.err", 32'(err), 1);
            chk("bad.w_en", 32'(spad_w_en), 0);
            chk("bad.r_en", 32'(spad_r_en), 0);
            chk("bad.in_ready", 32'(in_ready), 0);
            @(negedge clk);
            #1;
            chk_quiet("bad.after");
            return;
        end
        chk("t1.in_ready", 32'(in_ready), 1);

        while (w < len && cyc < 5000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = 8'($urandom);
            if (!gaps) in_data = 8'(8'h10 + w);
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                cfg_len = 7'($urandom_range(1, 64));
                cfg_filt = 5'($urandom_range(1, 16));
            end
            #1;
            chk("ld.in_ready", 32'(in_ready), 1);
            chk("ld.w_en", 32'(spad_w_en), 32'(in_valid));
            chk("ld.r_en", 32'(spad_r_en), 0);
            chk("ld.mac_valid", 32'(mac_valid), 0);
            if (in_valid) begin
                chk("ld.w_addr", 32'(spad_w_addr), 32'(w));
                chk("ld.w_data", 32'(spad_w_data), 32'(in_data));
                w++;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;

        while (taps < total && cyc < 5000) begin
            mac_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) start = 1'($urandom_range(0, 1));
            if (taps == abort) begin
                mac_ready = 1'b0;
                start = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                #1;
                chk_quiet("rst");
                chk("rst.w_addr", 32'(spad_w_addr), 0);
                chk("rst.r_addr", 32'(spad_r_addr), 0);
                chk("rst.w_data", 32'(spad_w_data), 32'(in_data));
                rst = 1'b0;
                return;
            end
            #1;
            chk("cp.mac_valid", 32'(mac_valid), 1);
            chk("cp.r_en", 32'(spad_r_en), 1);
            chk("cp.r_addr", 32'(spad_r_addr), 32'(b + t));
            chk("cp.first", 32'(mac_first), 32'(t == 0));
            chk("cp.last", 32'(mac_last), 32'(t == filt - 1));
            chk("cp.w_en", 32'(spad_w_en), 0);
            chk("cp.done", 32'(done), 0);
            if (mac_ready) begin
                taps++;
                if (t == filt - 1) begin
                    t = 0;
                    b++;
                end else begin
                    t++;
                end
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        mac_ready = 1'b0;
        if (cyc >= 5000) chk("timeout", 1, 0);
        #1;
        chk("fin.done", 32'(done), 1);
        chk("fin.err", 32'(err), 0);
        chk("fin.busy", 32'(busy), 1);
        chk("fin.mac_valid", 32'(mac_valid), 0);
        @(negedge clk);
        #1;
        chk_quiet("idle");
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_len = '0;
        cfg_filt = '0;
        in_valid = 1'b0;
        in_data = 8'h5a;
        mac_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset");
        chk("reset.w_addr", 32'(spad_w_addr), 0);
        chk("reset.r_addr", 32'(spad_r_addr), 0);
        chk("reset.w_data", 32'(spad_w_data), 32'h5a);
        rst = 1'b0;

        run_job(8, 3, 1'b0, 1'b0, -1);
        run_job(64, 16, 1'b1, 1'b0, -1);
        run_job(5, 6, 1'b0, 1'b0, -1);
        run_job(0, 3, 1'b0, 1'b0, -1);
        run_job(65, 3, 1'b0, 1'b0, -1);
        run_job(8, 0, 1'b0, 1'b0, -1);
        run_job(4, 1, 1'b0, 1'b0, -1);
        run_job(6, 6, 1'b0, 1'b0, -1);
        run_job(8, 3, 1'b0, 1'b0, 7);
        run_job(4, 1, 1'b0, 1'b0, -1);
        run_job(12, 4, 1'b1, 1'b1, -1);
        run_job(64, 1, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifmap_spad_ctrl.md
# ifmap_spad_ctrl

Sequencer for the PE's 64-entry x 8-bit ifmap scratchpad (ifmap_spad). Loads one ifmap row from the GLB-side stream into the spad, then replays it as stride-1 sliding windows of width S to the PE MAC datapath over a valid/ready handshake. It owns every spad write/read control signal, so the spad needs no other master.

## Interface
- DATA_W, 8, ifmap element width
- DEPTH, 64, spad entries
- ADDR_W, 6, spad address width (log2 DEPTH)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a job; sampled only in IDLE
- cfg_len  in  7  ifmap row length L, legal 1..64; latched on accepted start
- cfg_filt  in  5  filter width S, legal 1..16; latched on accepted start
- in_valid / in_ready  in / out  1  load stream handshake
- in_data  in  DATA_W  load element
- spad_w_en  out  1  spad write enable
- spad_w_addr  out  ADDR_W  spad write address
- spad_w_data  out  DATA_W  spad write data (= in_data)
- spad_r_en  out  1  spad read enable
- spad_r_addr  out  ADDR_W  spad read address
- mac_valid / mac_ready  out / in  1  window-tap handshake; tap data is spad read_data in the same cycle
- mac_first  out  1  current tap is tap 0 of a window
- mac_last  out  1  current tap is tap S-1 of a window
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  one-cycle pulse with done when config illegal

## Operation
- States: IDLE, LOAD, COMP, FIN.
- IDLE: in_ready=0, no spad access. start=1 -> latch cfg, clear counters; legal cfg -> LOAD, illegal (L=0, L>64, S=0, S>L) -> FIN with err flagged.
- LOAD: in_ready=1; each in_valid&in_ready writes in_data at spad_w_addr=wcnt (spad_w_en=in_valid&in_ready, combinational), wcnt++. Accept of element L-1 -> COMP next cycle.
- COMP: spad_r_en=1, mac_valid=1, spad_r_addr=base+tap. On mac_valid&mac_ready: tap==S-1 -> tap=0, base++; else tap++. Transfer with base==L-S and tap==S-1 -> FIN. mac_ready low: address and flags hold.
- Windows issued: L-S+1; total taps: (L-S+1)*S. base+tap <= L-1 always; arithmetic in 7 bits, address = low 6 bits.
- mac_first = COMP & tap==0; mac_last = COMP & tap==S-1.
- FIN: done=1 (err=1 if illegal), then IDLE. start in FIN/LOAD/COMP ignored.
- Controller never clears spad contents; stale data beyond L is never read.

## Timing
- Reset: state IDLE, counters 0; in_ready, spad_w_en, spad_r_en, mac_valid, mac_first, mac_last, busy, done, err = 0; addresses/data outputs 0 (spad_w_data follows in_data).
- rst mid-job: next edge IDLE, all outputs as above; partially loaded spad data abandoned.
- start at cycle t -> busy=1 and in_ready=1 at t+1.
- Last load accept at t -> first tap (mac_valid, mac_first, addr 0) at t+1.
- Last tap transfer at t -> done at t+1, busy=0 at t+2.
- Full-throughput job (in_valid, mac_ready held 1): 1 + L + (L-S+1)*S + 1 cycles start-to-done inclusive of FIN.
- L=S: single window; S=1: every tap has mac_first=mac_last=1.

## Structure
- Package ifmap_spad_pkg: state enum (IDLE/LOAD/COMP/FIN), DATA_W, DEPTH, ADDR_W, cfg widths, MAX_FILT=16.
- One sub-module natural: ifmap_win_agen (base/tap counters, first/last/final flags, advance on fire). FSM and load counter stay in top.

## Test plan
- L=8, S=3, stream 0x10..0x17, mac_ready=1 -> addresses 0,1,2,1,2,3,...,5,6,7 (18 taps), mac_first on taps 0,3,..., done 1 cycle after last.
- L=64, S=16 with random in_valid/mac_ready gaps -> 49 windows, 784 taps, no address beyond 63, holds stable while stalled.
- L=5, S=6 (and L=0, L=65, S=0) -> no spad access, done=err=1 one cycle after start.
- L=4, S=1 -> 4 taps at addr 0..3, each with mac_first=mac_last=1.
- rst asserted mid-COMP with mac_ready=0 -> next cycle all outputs 0, IDLE; new start then runs a clean job.
- start pulsed during LOAD and COMP -> ignored, cfg unchanged, single done.
